babbage_scheduler: RTL and testbench

BABBAGE_SCHEDULER -- requirements
Module: babbage_scheduler

---
 rtl/babbage_pkg.sv | 26 ++
 rtl/babbage_rr_arbiter.sv | 33 +++
 rtl/babbage_scheduler.sv | 148 ++++++++++++++
 tb/tb_babbage_scheduler.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/babbage_pkg.sv
// Shared types and constants for the Babbage difference-engine scheduler.
// Holds the FSM encoding, default sizing and response-flag values.
package babbage_pkg;

  localparam int unsigned NREQ_DEF    = 4;
  localparam int unsigned NW_DEF      = 8;
  localparam int unsigned DW_DEF      = 32;
  localparam int unsigned TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // resp_err encoding
  localparam logic RESP_OK  = 1'b0;
  localparam logic RESP_ERR = 1'b1;

  // Index width that stays legal for a single-entry range.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/babbage_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after i_ptr,
// wrapping modulo NREQ.
module babbage_rr_arbiter
  import babbage_pkg::*;
#(
  parameter  int unsigned NREQ = NREQ_DEF,
  localparam int unsigned IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  logic [IW-1:0] w_j;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_j = IW'((32'(i_ptr) + k) % NREQ);
      if (!o_any && i_req[w_j]) begin
        o_any        = 1'b1;
        o_idx        = w_j;
        o_grant[w_j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/babbage_scheduler.sv
// Shares one difference engine among NREQ requesters: round-robin grant,
// single job in flight, timeout abort and held response with backpressure.
module babbage_scheduler
  import babbage_pkg::*;
#(
  parameter int unsigned NREQ    = NREQ_DEF,
  parameter int unsigned NW      = NW_DEF,
  parameter int unsigned DW      = DW_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF,
  localparam int unsigned IW     = idx_w(NREQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*NW-1:0] req_n,
  output logic [NREQ-1:0]    req_ack,
  input  logic               eng_ready,
  output logic               eng_start,
  output logic [NW-1:0]      eng_n,
  input  logic               eng_done_tick,
  input  logic [DW-1:0]      eng_result,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [IW-1:0]      resp_id,
  output logic [DW-1:0]      resp_data,
  output logic               resp_err,
  output logic               busy
);

  localparam int unsigned CW = idx_w(TIMEOUT);

  state_e          r_state;
  logic [IW-1:0]   r_ptr;
  logic [IW-1:0]   r_owner;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_req_ack;
  logic            r_eng_start;
  logic [NW-1:0]   r_eng_n;
  logic            r_resp_valid;
  logic [IW-1:0]   r_resp_id;
  logic [DW-1:0]   r_resp_data;
  logic            r_resp_err;
  logic            r_busy;

  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic [NW-1:0]   w_n_sel;
  logic [IW-1:0]   w_ptr_nxt;

  babbage_rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_n_sel   = req_n[w_idx*NW +: NW];
  assign w_ptr_nxt = (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + IW'(1);

  // Job sequencer; ack/start are one-cycle pulses cleared by default.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_ptr        <= '0;
      r_owner      <= '0;
      r_cnt        <= '0;
      r_req_ack    <= '0;
      r_eng_start  <= 1'b0;
      r_eng_n      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_data  <= '0;
      r_resp_err   <= RESP_OK;
      r_busy       <= 1'b0;
    end else begin
      r_req_ack   <= '0;
      r_eng_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any && eng_ready) begin
            r_owner     <= w_idx;
            r_eng_n     <= w_n_sel;
            r_ptr       <= w_ptr_nxt;
            r_req_ack   <= w_grant;
            r_eng_start <= (w_n_sel != '0);
            r_busy      <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (r_eng_n != '0) begin
            r_cnt   <= '0;
            r_state <= ST_WAIT;
          end else begin
            r_resp_valid <= 1'b1;
            r_resp_id    <= r_owner;
            r_resp_data  <= '0;
            r_resp_err   <= RESP_ERR;
            r_state      <= ST_RESP;
          end
        end
        ST_WAIT: begin
          // Completion wins over a timeout landing on the same cycle.
          if (eng_done_tick) begin
            r_resp_valid <= 1'b1;
            r_resp_id    <= r_owner;
            r_resp_data  <= eng_result;
            r_resp_err   <= RESP_OK;
            r_state      <= ST_RESP;
          end else if (r_cnt == CW'(TIMEOUT - 1)) begin
            r_resp_valid <= 1'b1;
            r_resp_id    <= r_owner;
            r_resp_data  <= '0;
            r_resp_err   <= RESP_ERR;
            r_state      <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign req_ack    = r_req_ack;
  assign eng_start  = r_eng_start;
  assign eng_n      = r_eng_n;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_babbage_scheduler.sv
// Directed self-checking bench for babbage_scheduler (NREQ=4, NW=8, DW=32, TIMEOUT=16).
module tb_babbage_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_n;
  logic [3:0]  req_ack;
  logic        eng_ready;
  logic        eng_start;
  logic [7:0]  eng_n;
  logic        eng_done_tick;
  logic [31:0] eng_result;
  logic        resp_valid;
  logic        resp_ready;
  logic [1:0]  resp_id;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  babbage_scheduler #(
    .NREQ(4), .NW(8), .DW(32), .TIMEOUT(16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_n         (req_n),
    .req_ack       (req_ack),
    .eng_ready     (eng_ready),
    .eng_start     (eng_start),
    .eng_n         (eng_n),
    .eng_done_tick (eng_done_tick),
    .eng_result    (eng_result),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_data     (resp_data),
    .resp_err      (resp_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs();
    req_valid     = '0;
    req_n         = '0;
    eng_ready     = 1'b0;
    eng_done_tick = 1'b0;
    eng_result    = '0;
    resp_ready    = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    @(negedge clk);
    checks++;
    if ({req_ack, eng_start, eng_n, resp_valid, resp_id, resp_data, resp_err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b start=%b n=%h rv=%b id=%0d data=%h err=%b busy=%b, all 0 required",
               req_ack, eng_start, eng_n, resp_valid, resp_id, resp_data, resp_err, busy);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_job();
    do_reset();
    req_n[2*8 +: 8] = 8'd5;
    req_valid = 4'b0100;
    eng_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ack !== 4'b0100 || eng_start !== 1'b1 || eng_n !== 8'd5 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_issue: ack=%b start=%b n=%0d busy=%b, need 0100 1 5 1", req_ack, eng_start, eng_n, busy);
    end
    req_valid = '0;
    eng_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ack !== 4'b0000 || eng_start !== 1'b0) begin
      errors++;
      $display("FAIL single_pulse: ack=%b start=%b, need 0000 0", req_ack, eng_start);
    end
    eng_done_tick = 1'b1;
    eng_result    = 32'h7D;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_data !== 32'h7D || resp_err !== 1'b0 || eng_n !== 8'd5) begin
      errors++;
      $display("FAIL single_resp: rv=%b id=%0d data=%h err=%b n=%0d, need 1 2 7d 0 5",
               resp_valid, resp_id, resp_data, resp_err, eng_n);
    end
    eng_done_tick = 1'b0;
    resp_ready    = 1'b1;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done: rv=%b busy=%b, need 0 0", resp_valid, busy);
    end
    resp_ready = 1'b0;
  endtask

  task automatic test_ready_gate();
    do_reset();
    req_n[0 +: 8] = 8'd3;
    req_valid = 4'b0001;
    eng_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (req_ack !== 4'b0000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL gate_hold: cycle %0d ack=%b busy=%b, need 0000 0", i, req_ack, busy);
      end
    end
    eng_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ack !== 4'b0001) begin
      errors++;
      $display("FAIL gate_release: ack=%b, need 0001", req_ack);
    end
    req_valid = '0;
    @(negedge clk);
    eng_done_tick = 1'b1;
    eng_result    = 32'h1;
    @(negedge clk);
    eng_done_tick = 1'b0;
    resp_ready    = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_fairness();
    int          order [5] = '{0, 1, 2, 3, 0};
    logic [3:0]  exp_ack;
    int          cyc;
    do_reset();
    req_n      = 32'h03030303;
    req_valid  = 4'b1111;
    eng_ready  = 1'b1;
    resp_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      exp_ack = 4'b0001 << order[g];
      cyc = 0;
      while (req_ack === 4'b0000 && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (req_ack !== exp_ack) begin
        errors++;
        $display("FAIL fair_grant%0d: ack=%b, need %b", g, req_ack, exp_ack);
      end
      @(negedge clk);
      checks++;
      if (req_ack !== 4'b0000) begin
        errors++;
        $display("FAIL fair_ack_once%0d: ack=%b, need 0000", g, req_ack);
      end
      eng_done_tick = 1'b1;
      eng_result    = 32'(g);
      @(negedge clk);
      eng_done_tick = 1'b0;
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'(order[g]) || resp_data !== 32'(g)) begin
        errors++;
        $display("FAIL fair_resp%0d: rv=%b id=%0d data=%h, need 1 %0d %h", g, resp_valid, resp_id, resp_data, order[g], g);
      end
    end
    req_valid = '0;
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL fair_idle: busy=%b, need 0", busy);
    end
  endtask

  task automatic test_zero_count();
    do_reset();
    req_n     = 32'h09090009;
    req_valid = 4'b0010;
    eng_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ack !== 4'b0010 || eng_start !== 1'b0) begin
      errors++;
      $display("FAIL zero_issue: ack=%b start=%b, need 0010 0", req_ack, eng_start);
    end
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_err !== 1'b1 || resp_data !== 32'h0 || eng_start !== 1'b0) begin
      errors++;
      $display("FAIL zero_resp: rv=%b id=%0d err=%b data=%h start=%b, need 1 1 1 0 0",
               resp_valid, resp_id, resp_err, resp_data, eng_start);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int first;
    int j;
    do_reset();
    req_n[3*8 +: 8] = 8'd7;
    req_valid = 4'b1000;
    eng_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (eng_start !== 1'b1) begin
      errors++;
      $display("FAIL tmo_start: start=%b, need 1", eng_start);
    end
    req_valid = '0;
    first = 0;
    j = 0;
    while (first == 0 && j < 40) begin
      @(negedge clk);
      j++;
      if (resp_valid === 1'b1) first = j;
    end
    checks++;
    if (first != 17) begin
      errors++;
      $display("FAIL tmo_latency: resp after %0d cycles, need 17 (16 wait cycles)", first);
    end
    checks++;
    if (resp_err !== 1'b1 || resp_data !== 32'h0 || resp_id !== 2'd3) begin
      errors++;
      $display("FAIL tmo_resp: err=%b data=%h id=%0d, need 1 0 3", resp_err, resp_data, resp_id);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  task automatic test_double_done();
    int nresp;
    req_n[0 +: 8] = 8'd2;
    req_valid  = 4'b0001;
    eng_ready  = 1'b1;
    resp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (eng_start !== 1'b1) begin
      errors++;
      $display("FAIL dbl_start: start=%b, need 1", eng_start);
    end
    req_valid = '0;
    @(negedge clk);
    eng_done_tick = 1'b1;
    eng_result    = 32'hAA;
    nresp = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) eng_done_tick = 1'b0;
      if (resp_valid === 1'b1) nresp++;
    end
    checks++;
    if (nresp != 1 || resp_data !== 32'hAA) begin
      errors++;
      $display("FAIL dbl_once: responses=%0d data=%h, need 1 aa", nresp, resp_data);
    end
    resp_ready = 1'b0;
  endtask

  task automatic test_backpressure_reset();
    do_reset();
    req_n      = 32'h09090604;
    req_valid  = 4'b0001;
    eng_ready  = 1'b1;
    resp_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ack !== 4'b0001) begin
      errors++;
      $display("FAIL bp_ack0: ack=%b, need 0001", req_ack);
    end
    req_valid = 4'b0010;
    @(negedge clk);
    eng_done_tick = 1'b1;
    eng_result    = 32'h12345678;
    @(negedge clk);
    eng_done_tick = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 32'h12345678 || resp_id !== 2'd0 || resp_err !== 1'b0 ||
          req_ack !== 4'b0000 || eng_start !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: rv=%b data=%h id=%0d err=%b ack=%b start=%b, need 1 12345678 0 0 0000 0",
                 i, resp_valid, resp_data, resp_id, resp_err, req_ack, eng_start);
      end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    checks++;
    if (resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_xfer: rv=%b, need 0", resp_valid);
    end
    @(negedge clk);
    checks++;
    if (req_ack !== 4'b0010 || eng_n !== 8'd6) begin
      errors++;
      $display("FAIL bp_pending: ack=%b n=%0d, need 0010 6", req_ack, eng_n);
    end
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({req_ack, eng_start, eng_n, resp_valid, resp_id, resp_data, resp_err, busy} !== '0) begin
      errors++;
      $display("FAIL rst_wait: ack=%b start=%b n=%h rv=%b id=%0d data=%h err=%b busy=%b, all 0 required",
               req_ack, eng_start, eng_n, resp_valid, resp_id, resp_data, resp_err, busy);
    end
    reset     = 1'b0;
    req_valid = 4'b1111;
    @(negedge clk);
    checks++;
    if (req_ack !== 4'b0001 || resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_ptr: ack=%b rv=%b, need 0001 0", req_ack, resp_valid);
    end
    req_valid = '0;
    @(negedge clk);
    eng_done_tick = 1'b1;
    @(negedge clk);
    eng_done_tick = 1'b0;
    resp_ready    = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_single_job();
    test_ready_gate();
    test_fairness();
    test_zero_count();
    test_timeout();
    test_double_done();
    test_backpressure_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
